// File: rtl/adc_link_pkg.sv
// Shared constants and types for the serial ADC data lane (transmitter and receiver side).
package adc_link_pkg;

   localparam int         ADC_WIDTH         = 6;
   localparam logic [5:0] ADC_TRAIN_PATTERN = 6'b111000;
   localparam logic [5:0] ADC_IDLE_WORD     = 6'b000000;

   // PRBS7: x^7 + x^6 + 1, feedback taps on state bits 6 and 5
   localparam logic [6:0] PRBS7_TAPS = 7'b1100000;
   localparam logic [6:0] PRBS7_SEED = 7'h7F;

   typedef enum logic {
      MODE_DATA     = 1'b0,
      MODE_TRAINING = 1'b1
   } mode_e;

endpackage

// File: rtl/adc_prbs7_gen.sv
// PRBS7 generator presenting the next WIDTH sequence bits (first bit in the MSB) and
// stepping WIDTH positions on each advance.
module adc_prbs7_gen
   import adc_link_pkg::*;
#(
   parameter int WIDTH = ADC_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   output logic [WIDTH-1:0] word
);

   logic [6:0] state;
   logic [6:0] state_nx;

   always_comb begin : gen_bits
      logic [6:0] s;
      logic       nb;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      s        = state;
      nb       = 1'b0;
      word     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nb                = ^(s & PRBS7_TAPS);
         word[WIDTH-1-i]   = nb;
         s                 = {s[5:0], nb};
      end
      state_nx = s;
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst)          state <= PRBS7_SEED;
      else if (advance) state <= state_nx;
   end

endmodule

// File: rtl/adc_ser_tx.sv
// Serial ADC lane transmitter: WIDTH-bit frames, MSB first, with frame clock, training
// pattern and underflow count. Define ADCTX_PRBS_EN to add the PRBS7 test mode on TEST.
module adc_ser_tx
   import adc_link_pkg::*;
#(
   parameter int               WIDTH         = ADC_WIDTH,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(ADC_TRAIN_PATTERN),
   parameter logic [WIDTH-1:0] IDLE_WORD     = WIDTH'(ADC_IDLE_WORD)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DVALID,
   output logic             DREADY,
   input  logic             TRAIN,
   input  logic             UFCLR,
   input  logic             TEST,
   output logic             SOUT,
   output logic             FCO,
   output logic [15:0]      UFCNT
);

   localparam int            CW      = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(WIDTH / 2 - 1);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shift;
   logic             sout_q;
   logic             fco_q;
   logic             loaded;
   logic [15:0]      ufcnt_q;
   mode_e            mode;
   mode_e            next_mode;

   logic             boundary;
   logic             prbs_sel;
   logic [WIDTH-1:0] prbs_word;
   logic             underflow;
   logic [WIDTH-1:0] load_word;

   assign boundary = (cnt == LAST);

`ifdef ADCTX_PRBS_EN
   assign prbs_sel = TEST;

   adc_prbs7_gen #(.WIDTH(WIDTH)) u_prbs (
      .clk     (CLK),
      .rst     (RST),
      .advance (boundary && (next_mode == MODE_DATA) && TEST),
      .word    (prbs_word)
   );
`else
   assign prbs_sel  = 1'b0;
   assign prbs_word = '0;
`endif

   // Mode only changes at the frame boundary, so a TRAIN edge mid-frame cannot touch the word in flight.
   always_comb begin
      next_mode = mode;
      load_word = IDLE_WORD;
      underflow = 1'b0;
      if (boundary) begin
         next_mode = TRAIN ? MODE_TRAINING : MODE_DATA;
         if (next_mode == MODE_TRAINING) load_word = TRAIN_PATTERN;
         else if (prbs_sel)              load_word = prbs_word;
         else if (DVALID)                load_word = DIN;
         else                            underflow = 1'b1;
      end
   end

   assign DREADY = boundary && (next_mode == MODE_DATA) && !prbs_sel;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         shift   <= '0;
         sout_q  <= 1'b0;
         fco_q   <= 1'b0;
         loaded  <= 1'b0;
         ufcnt_q <= '0;
         mode    <= MODE_DATA;
      end else begin
         mode <= next_mode;
         cnt  <= boundary ? '0 : cnt + 1'b1;
         if (boundary) begin
            sout_q <= load_word[WIDTH-1];
            shift  <= {load_word[WIDTH-2:0], 1'b0};
            loaded <= 1'b1;
         end else begin
            sout_q <= shift[WIDTH-1];
            shift  <= {shift[WIDTH-2:0], 1'b0};
         end
         // High for the upper half of each frame; held low until the first word is loaded.
         fco_q <= boundary || (loaded && (cnt < HALF_M1));
         if (UFCLR)                                ufcnt_q <= '0;
         else if (underflow && (ufcnt_q != '1))    ufcnt_q <= ufcnt_q + 16'd1;
      end
   end

   assign SOUT  = sout_q;
   assign FCO   = fco_q;
   assign UFCNT = ufcnt_q;

endmodule

// File: tb/tb_adc_ser_tx.sv
// Directed bench for adc_ser_tx (WIDTH=6); inputs driven and outputs sampled on the falling edge.
module tb_adc_ser_tx;

   localparam int W = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic [W-1:0]  DIN;
   logic          DVALID;
   logic          DREADY;
   logic          TRAIN;
   logic          UFCLR;
   logic          TEST;
   logic          SOUT;
   logic          FCO;
   logic [15:0]   UFCNT;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   adc_ser_tx dut (
      .CLK    (CLK),
      .RST    (RST),
      .DIN    (DIN),
      .DVALID (DVALID),
      .DREADY (DREADY),
      .TRAIN  (TRAIN),
      .UFCLR  (UFCLR),
      .TEST   (TEST),
      .SOUT   (SOUT),
      .FCO    (FCO),
      .UFCNT  (UFCNT)
   );

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Leaves the DUT just after reset release with cnt=0, then walks to the first boundary (cnt=5).
   task automatic test_reset;
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      n_cmp++; if (SOUT !== 1'b0)       begin n_bad++; $display("FAIL reset_sout got %b want 0", SOUT); end
      n_cmp++; if (FCO !== 1'b0)        begin n_bad++; $display("FAIL reset_fco got %b want 0", FCO); end
      n_cmp++; if (UFCNT !== 16'h0000)  begin n_bad++; $display("FAIL reset_ufcnt got %h want 0000", UFCNT); end
      n_cmp++; if (DREADY !== 1'b0)     begin n_bad++; $display("FAIL reset_dready got %b want 0", DREADY); end
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_cmp++; if (SOUT !== 1'b0 || FCO !== 1'b0) begin
            n_bad++; $display("FAIL prefill_out cyc %0d got sout=%b fco=%b want 0/0", i, SOUT, FCO);
         end
         n_cmp++; if (DREADY !== (i == 5)) begin
            n_bad++; $display("FAIL prefill_dready cyc %0d got %b want %b", i, DREADY, (i == 5));
         end
      end
   endtask

   task automatic test_single;
      logic [W-1:0] exp_s;
      logic [W-1:0] exp_f;
      exp_s  = 6'b101101;
      exp_f  = 6'b111000;
      DIN    = 6'b101101;
      DVALID = 1'b1;
      for (int b = 0; b < W; b++) begin
         tick();
         if (b == 0) DVALID = 1'b0;
         n_cmp++; if (SOUT !== exp_s[W-1-b])  begin n_bad++; $display("FAIL single_sout bit %0d got %b want %b", b, SOUT, exp_s[W-1-b]); end
         n_cmp++; if (FCO !== exp_f[W-1-b])   begin n_bad++; $display("FAIL single_fco bit %0d got %b want %b", b, FCO, exp_f[W-1-b]); end
         n_cmp++; if (DREADY !== (b == W-1))  begin n_bad++; $display("FAIL single_dready bit %0d got %b want %b", b, DREADY, (b == W-1)); end
      end
   endtask

   task automatic test_back_to_back;
      logic [3*W-1:0] stream;
      logic [W-1:0]   exp_f;
      stream = {6'h3F, 6'h00, 6'h2A};
      exp_f  = 6'b111000;
      DVALID = 1'b1;
      for (int f = 0; f < 3; f++) begin
         DIN = stream[3*W-1-W*f -: W];
         for (int b = 0; b < W; b++) begin
            tick();
            n_cmp++; if (SOUT !== stream[3*W-1-W*f-b]) begin
               n_bad++; $display("FAIL b2b_sout frame %0d bit %0d got %b want %b", f, b, SOUT, stream[3*W-1-W*f-b]);
            end
            n_cmp++; if (FCO !== exp_f[W-1-b]) begin
               n_bad++; $display("FAIL b2b_fco frame %0d bit %0d got %b want %b", f, b, FCO, exp_f[W-1-b]);
            end
         end
      end
      DVALID = 1'b0;
      n_cmp++; if (UFCNT !== 16'h0000) begin n_bad++; $display("FAIL b2b_ufcnt got %h want 0000", UFCNT); end
   endtask

   task automatic test_underflow;
      DVALID = 1'b0;
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < W; b++) begin
            tick();
            n_cmp++; if (SOUT !== 1'b0) begin n_bad++; $display("FAIL uf_sout frame %0d bit %0d got %b want 0", f, b, SOUT); end
            if (b == 0) begin
               n_cmp++; if (UFCNT !== 16'(f + 1)) begin n_bad++; $display("FAIL uf_count frame %0d got %0d want %0d", f, UFCNT, f + 1); end
            end
         end
      end
      n_cmp++; if (UFCNT !== 16'd3) begin n_bad++; $display("FAIL uf_total got %0d want 3", UFCNT); end
      UFCLR = 1'b1;
      tick();
      UFCLR = 1'b0;
      n_cmp++; if (UFCNT !== 16'd0) begin n_bad++; $display("FAIL uf_clear_wins got %0d want 0", UFCNT); end
      for (int i = 0; i < W-1; i++) tick();
      n_cmp++; if (UFCNT !== 16'd0)  begin n_bad++; $display("FAIL uf_after_clear got %0d want 0", UFCNT); end
      n_cmp++; if (DREADY !== 1'b1)  begin n_bad++; $display("FAIL uf_dready got %b want 1", DREADY); end
   endtask

   task automatic test_training;
      logic [W-1:0] data0;
      logic [W-1:0] data1;
      logic [W-1:0] tp;
      logic [W-1:0] exp_f;
      data0 = 6'b010011;
      data1 = 6'b110101;
      tp    = 6'b111000;
      exp_f = 6'b111000;
      DIN    = data0;
      DVALID = 1'b1;
      for (int b = 0; b < W; b++) begin
         tick();
         if (b == 0) DVALID = 1'b0;
         if (b == 2) TRAIN = 1'b1;
         n_cmp++; if (SOUT !== data0[W-1-b]) begin n_bad++; $display("FAIL train_inflight bit %0d got %b want %b", b, SOUT, data0[W-1-b]); end
      end
      n_cmp++; if (DREADY !== 1'b0) begin n_bad++; $display("FAIL train_dready_gate got %b want 0", DREADY); end
      for (int f = 0; f < 2; f++) begin
         for (int b = 0; b < W; b++) begin
            tick();
            n_cmp++; if (SOUT !== tp[W-1-b])    begin n_bad++; $display("FAIL train_sout frame %0d bit %0d got %b want %b", f, b, SOUT, tp[W-1-b]); end
            n_cmp++; if (FCO !== exp_f[W-1-b])  begin n_bad++; $display("FAIL train_fco frame %0d bit %0d got %b want %b", f, b, FCO, exp_f[W-1-b]); end
            n_cmp++; if (DREADY !== 1'b0)       begin n_bad++; $display("FAIL train_dready frame %0d bit %0d got %b want 0", f, b, DREADY); end
         end
      end
      n_cmp++; if (UFCNT !== 16'd0) begin n_bad++; $display("FAIL train_ufcnt got %0d want 0", UFCNT); end
      TRAIN = 1'b0;
      #1;
      n_cmp++; if (DREADY !== 1'b1) begin n_bad++; $display("FAIL train_resume_dready got %b want 1", DREADY); end
      DIN    = data1;
      DVALID = 1'b1;
      for (int b = 0; b < W; b++) begin
         tick();
         if (b == 0) DVALID = 1'b0;
         n_cmp++; if (SOUT !== data1[W-1-b]) begin n_bad++; $display("FAIL train_resume_sout bit %0d got %b want %b", b, SOUT, data1[W-1-b]); end
      end
   endtask

   task automatic test_reset_mid;
      DVALID = 1'b0;
      tick();
      n_cmp++; if (UFCNT !== 16'd1) begin n_bad++; $display("FAIL rstmid_pre_ufcnt got %0d want 1", UFCNT); end
      for (int i = 0; i < W-1; i++) tick();
      DIN    = 6'h3F;
      DVALID = 1'b1;
      tick();
      DVALID = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++; if (SOUT !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_sout got %b want 1", SOUT); end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_cmp++; if (SOUT !== 1'b0)    begin n_bad++; $display("FAIL rstmid_sout got %b want 0", SOUT); end
      n_cmp++; if (FCO !== 1'b0)     begin n_bad++; $display("FAIL rstmid_fco got %b want 0", FCO); end
      n_cmp++; if (UFCNT !== 16'd0)  begin n_bad++; $display("FAIL rstmid_ufcnt got %0d want 0", UFCNT); end
      for (int i = 1; i <= W-1; i++) begin
         tick();
         n_cmp++; if (SOUT !== 1'b0 || FCO !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_quiet cyc %0d got sout=%b fco=%b want 0/0", i, SOUT, FCO);
         end
         n_cmp++; if (DREADY !== (i == W-1)) begin
            n_bad++; $display("FAIL rstmid_dready cyc %0d got %b want %b", i, DREADY, (i == W-1));
         end
      end
      DIN    = 6'h3F;
      DVALID = 1'b1;
      tick();
      DVALID = 1'b0;
      n_cmp++; if (SOUT !== 1'b1 || FCO !== 1'b1) begin
         n_bad++; $display("FAIL rstmid_first_frame got sout=%b fco=%b want 1/1", SOUT, FCO);
      end
      for (int i = 0; i < W-1; i++) tick();
   endtask

   // A full 65540-frame run is too long here; the counter is preset near the top instead.
   task automatic test_saturate;
      logic [15:0] exp_cnt;
      DVALID = 1'b0;
      force dut.ufcnt_q = 16'hFFFC;
      #1;
      release dut.ufcnt_q;
      for (int k = 1; k <= 5; k++) begin
         for (int b = 0; b < W; b++) tick();
         exp_cnt = (k >= 3) ? 16'hFFFF : 16'(32'hFFFC + k);
         n_cmp++; if (UFCNT !== exp_cnt) begin n_bad++; $display("FAIL sat_ufcnt step %0d got %h want %h", k, UFCNT, exp_cnt); end
      end
   endtask

`ifdef ADCTX_PRBS_EN
   task automatic test_prbs;
      logic [6:0]   s;
      logic [W-1:0] exp_w;
      RST  = 1'b1;
      TEST = 1'b1;
      tick();
      RST  = 1'b0;
      for (int i = 0; i < W-1; i++) tick();
      n_cmp++; if (DREADY !== 1'b0) begin n_bad++; $display("FAIL prbs_dready got %b want 0", DREADY); end
      s = 7'h7F;
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < W; b++) begin
            exp_w[W-1-b] = s[6] ^ s[5];
            s            = {s[5:0], s[6] ^ s[5]};
         end
         for (int b = 0; b < W; b++) begin
            tick();
            n_cmp++; if (SOUT !== exp_w[W-1-b]) begin n_bad++; $display("FAIL prbs_sout frame %0d bit %0d got %b want %b", f, b, SOUT, exp_w[W-1-b]); end
         end
      end
      n_cmp++; if (UFCNT !== 16'd0) begin n_bad++; $display("FAIL prbs_ufcnt got %0d want 0", UFCNT); end
      TEST = 1'b0;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      RST    = 1'b1;
      DIN    = '0;
      DVALID = 1'b0;
      TRAIN  = 1'b0;
      UFCLR  = 1'b0;
      TEST   = 1'b0;
      @(negedge CLK);
      test_reset();
      test_single();
      test_back_to_back();
      test_underflow();
      test_training();
      test_reset_mid();
      test_saturate();
`ifdef ADCTX_PRBS_EN
      test_prbs();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
